cache_fill_engine: RTL
======================

// Module: cache_fill_engine
// PURPOSE
//  Miss-refill writer for the 2-way, 64-set, 8-word/block cache data array.
//  On a miss it issues 8 pipelined word reads to main memory and writes each
//  returned word into the victim way. Writes use one-hot block/word enables
//  and per-way write enables. It then writes the tag/valid entry and pulses
//  fill_done. It sits between the cache controller, the memory and the array.
// PARAMETERS
//  ADDR_W     16  byte address width
//  DATA_W     16  word width
//  SET_BITS    6  set index bits (64 sets); index = addr[9:4]
//  WORD_BITS   3  word-offset bits (8 words); offset = addr[3:1]
//  TAG_W       6  tag width; tag = addr[15:10]
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous reset, active-low
//  miss          in   1        controller requests a refill (sampled in IDLE only)
//  miss_addr     in   ADDR_W   byte address that missed
//  victim_way    in   1        way to fill (0/1), sampled with miss
//  mem_en        out  1        memory read request, one word per cycle
//  mem_addr      out  ADDR_W   word read address
//  mem_valid     in   1        memory read data valid
//  mem_data      in   DATA_W   memory read data
//  arr_din       out  DATA_W   data to array (DataIn)
//  arr_wen0      out  1        write enable, way 0
//  arr_wen1      out  1        write enable, way 1
//  arr_blk_en    out  64       one-hot set enable
//  arr_word_en   out  8        one-hot word enable
//  tag_wen       out  2        one-hot per-way tag/valid write strobe
//  tag_out       out  TAG_W    tag to write; valid bit written as 1
//  busy          out  1        high from the cycle after miss acceptance until fill_done
//  fill_done     out  1        one-cycle pulse, fill complete
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; all outputs 0; counters 0; latched addr/way 0.
//  States: IDLE -> FILL -> TAGWR -> DONE -> IDLE.
//  IDLE:  miss=1 latches base = {miss_addr[15:4],4'h0}, set, tag, way; next FILL.
//  FILL:  issue side: mem_en=1 for exactly 8 consecutive cycles starting the first
//         FILL cycle. mem_addr = base + 2*iss_cnt with iss_cnt 0..7 (3-bit), then
//         mem_en=0. The issue side never waits on mem_valid.
//         Receive side: each mem_valid in FILL writes mem_data to word rcv_cnt.
//         The write is combinational in that cycle: arr_din=mem_data,
//         arr_word_en=1<<rcv_cnt, arr_blk_en=1<<set, arr_wen{way}=1, other wen 0.
//         rcv_cnt then increments. When the 8th word is written
//         (rcv_cnt==7 && mem_valid), next state is TAGWR.
//         Returns are in issue order; the engine counts valids, not latency.
//  TAGWR: tag_wen[way]=1, tag_out=latched tag, one cycle; next DONE.
//  DONE:  fill_done=1, busy=0 this cycle; next IDLE. A miss can be accepted on
//         the following cycle.
//  Outside writes, arr_blk_en, arr_word_en and arr_wen* are 0, so the array drives reads.
//  Boundaries:
//   - miss while busy: ignored, not queued.
//   - mem_valid in IDLE/TAGWR/DONE or a 9th valid: ignored, no array write.
//   - mem_valid on the same cycle as the first issue (zero latency): accepted.
//   - rst asserted mid-FILL: abort immediately. The tag is never written, so the
//     partially filled block stays invalid. No fill_done.
//   - miss_addr low bits [3:0] are ignored; the fill always starts at word 0.
// STRUCTURE
//  cache_pkg: ADDR_W/DATA_W/SET_BITS/WORD_BITS/TAG_W constants, field-extract
//   functions (get_set, get_tag, get_word), fill_state_t enum {IDLE,FILL,TAGWR,DONE}.
//  Sub-module: onehot_dec #(N) (binary -> one-hot), instanced for arr_blk_en
//   (N=6) and arr_word_en (N=3).
//  Registers: state, base, set, tag, way, iss_cnt+iss_done, rcv_cnt.
// TESTING
//  1 miss_addr=16'h1A36, way=1, mem latency 4 -> mem_addr 0x1A30..0x1A3E on 8
//    consecutive cycles. Valids write words 0..7 to set 0x23 with arr_wen1 only.
//    tag_wen=2'b10 with tag_out=6'h06. fill_done 1 cycle after TAGWR, busy low.
//  2 same as 1 with way=0 and mem latency 1 -> arr_wen0 only. Exactly 8 writes,
//    fill_done 11 cycles after miss.
//  3 mem_valid gapped (valid 1,0,1,0...) -> words still written in order 0..7.
//    The issue side finishes in 8 cycles regardless.
//  4 second miss pulsed mid-FILL, and a stray mem_valid in IDLE -> no effect.
//    No extra writes or requests.
//  5 rst low after 3 words -> all outputs 0 within the reset cycle, tag_wen never
//    asserted. A new miss after release completes a normal fill.
//  6 back-to-back misses (new miss the cycle after fill_done) -> second fill
//    is correct, no idle overlap errors.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants, address field helpers and the fill FSM state type
// for the cache refill engine.
package cache_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int SET_BITS  = 6;
  localparam int WORD_BITS = 3;
  localparam int TAG_W     = 6;

  // Bit positions of the address fields (byte address, 16-bit words)
  localparam int WORD_LSB = 1;
  localparam int SET_LSB  = WORD_LSB + WORD_BITS;
  localparam int TAG_LSB  = SET_LSB + SET_BITS;

  // Clears the byte/word offset so a fill always starts at word 0
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~(ADDR_W'((1 << SET_LSB) - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    TAGWR = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  function automatic logic [SET_BITS-1:0] get_set(input logic [ADDR_W-1:0] addr);
    return addr[SET_LSB +: SET_BITS];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [WORD_BITS-1:0] get_word(input logic [ADDR_W-1:0] addr);
    return addr[WORD_LSB +: WORD_BITS];
  endfunction

endpackage

// File: rtl/cache_fill_engine_onehot_dec.sv
// Binary to one-hot decoder with an enable; all zeros when disabled.
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]      bin,
  input  logic              en,
  output logic [(2**N)-1:0] onehot
);

  // Decode the binary index into a single asserted bit when enabled
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[bin] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/cache_fill_engine.sv
// Miss-refill writer: issues 8 pipelined word reads for the missing block,
// writes each returned word into the victim way of the data array, then
// writes the tag/valid entry and pulses fill_done.
module cache_fill_engine
  import cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic                    victim_way,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_valid,
  input  logic [DATA_W-1:0]       mem_data,
  output logic [DATA_W-1:0]       arr_din,
  output logic                    arr_wen0,
  output logic                    arr_wen1,
  output logic [(2**SET_BITS)-1:0]  arr_blk_en,
  output logic [(2**WORD_BITS)-1:0] arr_word_en,
  output logic [1:0]              tag_wen,
  output logic [TAG_W-1:0]        tag_out,
  output logic                    busy,
  output logic                    fill_done
);

  fill_state_t           state;
  fill_state_t           state_nxt;
  logic [ADDR_W-1:0]     base_addr;
  logic [SET_BITS-1:0]   set_idx;
  logic [TAG_W-1:0]      tag_lat;
  logic                  way_lat;
  logic [WORD_BITS-1:0]  iss_cnt;
  logic                  iss_done;
  logic [WORD_BITS-1:0]  rcv_cnt;

  // Issue side runs for 8 cycles unconditionally; receive side only counts valids
  logic issue_act;
  logic wr_act;
  logic [ADDR_W-1:0] addr_step;

  assign issue_act = (state == FILL) && !iss_done;
  assign wr_act    = (state == FILL) && mem_valid;
  assign addr_step = {{(ADDR_W-WORD_BITS-1){1'b0}}, iss_cnt, 1'b0};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = miss ? FILL : IDLE;
      FILL:    state_nxt = (wr_act && (rcv_cnt == 3'd7)) ? TAGWR : FILL;
      TAGWR:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and issue/receive counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_addr <= '0;
      set_idx   <= '0;
      tag_lat   <= '0;
      way_lat   <= 1'b0;
      iss_cnt   <= 3'd0;
      iss_done  <= 1'b0;
      rcv_cnt   <= 3'd0;
    end else if (state == IDLE) begin
      if (miss) begin
        base_addr <= miss_addr & BLOCK_MASK;
        set_idx   <= get_set(miss_addr);
        tag_lat   <= get_tag(miss_addr);
        way_lat   <= victim_way;
      end
      iss_cnt  <= 3'd0;
      iss_done <= 1'b0;
      rcv_cnt  <= 3'd0;
    end else if (state == FILL) begin
      if (issue_act) begin
        iss_cnt <= iss_cnt + 3'd1;
        if (iss_cnt == 3'd7) begin
          iss_done <= 1'b1;
        end
      end
      if (wr_act) begin
        rcv_cnt <= rcv_cnt + 3'd1;
      end
    end
  end

  // Output decode: memory requests, array write strobes, tag write, status
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    arr_din   = '0;
    arr_wen0  = 1'b0;
    arr_wen1  = 1'b0;
    tag_wen   = 2'b00;
    tag_out   = '0;
    busy      = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      FILL: begin
        busy   = 1'b1;
        mem_en = issue_act;
        if (issue_act) begin
          mem_addr = base_addr + addr_step;
        end else begin
          mem_addr = '0;
        end
        if (wr_act) begin
          arr_din  = mem_data;
          arr_wen0 = ~way_lat;
          arr_wen1 = way_lat;
        end else begin
          arr_din  = '0;
          arr_wen0 = 1'b0;
          arr_wen1 = 1'b0;
        end
      end
      TAGWR: begin
        busy    = 1'b1;
        tag_wen = way_lat ? 2'b10 : 2'b01;
        tag_out = tag_lat;
      end
      DONE: begin
        fill_done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  onehot_dec #(.N(SET_BITS)) u_blk_dec (
    .bin    (set_idx),
    .en     (wr_act),
    .onehot (arr_blk_en)
  );

  onehot_dec #(.N(WORD_BITS)) u_word_dec (
    .bin    (rcv_cnt),
    .en     (wr_act),
    .onehot (arr_word_en)
  );

endmodule
